mem_arbiter_ctrl: RTL and testbench

- Sequences the single byte-wide main-memory port and shares it between two requesters: instruction fetch (IF) and the MEM-stage load/store unit.
- Assembles and splits 1/2/4-byte little-endian accesses into per-byte RAM cycles.
- Returns a one-cycle done pulse to each requester.
- Drives mem_busy, which the pipeline stall logic uses to hold the MEM stage and the MEM-to-writeback register.

---
 rtl/mem_arbiter_ctrl_pkg.sv | 33 +++
 rtl/mem_arbiter_ctrl_byte_shifter.sv | 28 ++
 rtl/mem_arbiter_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mem_arbiter_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_ctrl_pkg.sv
// Shared definitions for the byte-wide memory port arbiter: FSM states,
// requester ownership, access size codes and global reset/enable levels.
package mem_arbiter_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_MEM
  } owner_t;

  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  localparam logic RST_ACTIVE = 1'b0;
  localparam logic EN_ACTIVE  = 1'b1;

  // Unsupported size codes fall back to a full word.
  function automatic logic [2:0] len_to_bytes(input logic [2:0] len);
    case (len)
      LEN_B:   return LEN_B;
      LEN_H:   return LEN_H;
      default: return LEN_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_ctrl_byte_shifter.sv
// Byte-lane steering for the arbiter: picks the outgoing store byte and
// merges incoming load bytes into a little-endian, zero-extended word.
module mem_byte_shifter
  import mem_arbiter_ctrl_pkg::*;
(
  input  logic [31:0] wdata,
  input  logic [1:0]  wr_idx,
  input  logic [31:0] acc,
  input  logic [1:0]  rd_idx,
  input  logic [7:0]  din,
  input  logic [2:0]  nbytes,
  output logic [7:0]  wr_byte,
  output logic [31:0] acc_next,
  output logic [31:0] rdata_ext
);

  always_comb begin
    wr_byte  = wdata[{wr_idx, 3'b000} +: 8];
    acc_next = acc;
    acc_next[{rd_idx, 3'b000} +: 8] = din;
    case (nbytes)
      LEN_B:   rdata_ext = {24'h000000, acc_next[7:0]};
      LEN_H:   rdata_ext = {16'h0000, acc_next[15:0]};
      default: rdata_ext = acc_next;
    endcase
  end

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Shares the byte-wide RAM port between instruction fetch and the MEM stage,
// splitting 1/2/4-byte accesses into per-byte cycles.
// Optional IO write backpressure: define MEM_ARB_IO_BACKPRESSURE_EN.
module mem_arbiter_ctrl
  import mem_arbiter_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned RAM_ADDR_W = 18,
  parameter logic [1:0]  IO_REGION  = 2'b11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  input  logic                  if_clear,
  output logic [31:0]           if_data,
  output logic                  if_done,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [2:0]            mem_len,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic [31:0]           mem_rdata,
  output logic                  mem_done,
  output logic                  mem_busy,
  input  logic [7:0]            ram_din,
  output logic [7:0]            ram_dout,
  output logic [RAM_ADDR_W-1:0] ram_a,
  output logic                  ram_wr,
  input  logic                  io_full
);

  state_t                state_q;
  owner_t                owner_q;
  logic [RAM_ADDR_W-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           acc_q;
  logic [2:0]            nbytes_q;
  logic [2:0]            cnt_q;
  logic                  ram_wr_q;

  logic                  req_any;
  logic                  req_we;
  logic [RAM_ADDR_W-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic [2:0]            req_nbytes;
  logic [2:0]            cnt_inc;
  logic [RAM_ADDR_W-1:0] next_addr;
  logic                  stall;
  logic [7:0]            wr_byte;
  logic [31:0]           acc_next;
  logic [31:0]           rdata_ext;
  logic                  unused_ok;

  always_comb begin
    req_any = mem_req | if_req;
    if (mem_req) begin
      req_addr   = mem_addr[RAM_ADDR_W-1:0];
      req_wdata  = mem_wdata;
      req_nbytes = len_to_bytes(mem_len);
      req_we     = mem_we;
    end else begin
      req_addr   = if_addr[RAM_ADDR_W-1:0];
      req_wdata  = '0;
      req_nbytes = LEN_W;
      req_we     = 1'b0;
    end
  end

  assign cnt_inc   = cnt_q + 3'd1;
  assign next_addr = addr_q + RAM_ADDR_W'(cnt_inc);

`ifdef MEM_ARB_IO_BACKPRESSURE_EN
  assign stall = (state_q == ST_WRITE) && (addr_q[17:16] == IO_REGION) && io_full;
`else
  assign stall = 1'b0;
`endif

  // The stall must suppress the write in the same cycle io_full is seen.
  assign ram_wr = ram_wr_q & ~stall;

  assign mem_busy = (rst != RST_ACTIVE) &
                    (mem_req | ((state_q != ST_IDLE) & (owner_q == OWN_MEM) & ~mem_done));

  assign unused_ok = ^{io_full, IO_REGION, if_addr[ADDR_W-1:RAM_ADDR_W],
                       mem_addr[ADDR_W-1:RAM_ADDR_W]};

  mem_byte_shifter u_shifter (
    .wdata     (wdata_q),
    .wr_idx    (cnt_inc[1:0]),
    .acc       (acc_q),
    .rd_idx    (cnt_q[1:0] - 2'd1),
    .din       (ram_din),
    .nbytes    (nbytes_q),
    .wr_byte   (wr_byte),
    .acc_next  (acc_next),
    .rdata_ext (rdata_ext)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_IF;
      addr_q    <= '0;
      wdata_q   <= '0;
      acc_q     <= '0;
      nbytes_q  <= '0;
      cnt_q     <= '0;
      ram_wr_q  <= 1'b0;
      ram_a     <= '0;
      ram_dout  <= '0;
      if_data   <= '0;
      mem_rdata <= '0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
    end else if (rdy == EN_ACTIVE) begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_any) begin
            owner_q  <= mem_req ? OWN_MEM : OWN_IF;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            nbytes_q <= req_nbytes;
            cnt_q    <= '0;
            acc_q    <= '0;
            ram_a    <= req_addr;
            if (req_we) begin
              state_q  <= ST_WRITE;
              ram_wr_q <= 1'b1;
              ram_dout <= req_wdata[7:0];
            end else begin
              state_q <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if ((owner_q == OWN_IF) && if_clear) begin
            state_q <= ST_IDLE;
          end else begin
            // Data lags the address by one cycle, so byte cnt-1 arrives now.
            if (cnt_q != '0) acc_q <= acc_next;
            if (cnt_q == nbytes_q) begin
              state_q <= ST_DONE;
              if (owner_q == OWN_MEM) begin
                mem_rdata <= rdata_ext;
                mem_done  <= 1'b1;
              end else begin
                if_data <= rdata_ext;
                if_done <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_inc;
              if (cnt_inc != nbytes_q) ram_a <= next_addr;
            end
          end
        end
        ST_WRITE: begin
          if (!stall) begin
            if (cnt_inc == nbytes_q) begin
              ram_wr_q <= 1'b0;
              state_q  <= ST_DONE;
              mem_done <= 1'b1;
            end else begin
              cnt_q    <= cnt_inc;
              ram_a    <= next_addr;
              ram_dout <= wr_byte;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Self-checking bench for mem_arbiter_ctrl: directed scenarios plus random
// IF/load/store traffic checked against a byte-array memory model.
module tb_mem_arbiter_ctrl;

  localparam int unsigned RAM_ADDR_W = 18;
  localparam int unsigned RAM_SIZE   = 1 << RAM_ADDR_W;
`ifdef MEM_ARB_IO_BACKPRESSURE_EN
  localparam int IO_DONE_LAT = 6;
  localparam int IO_EARLY_WR = 0;
`else
  localparam int IO_DONE_LAT = 2;
  localparam int IO_EARLY_WR = 1;
`endif

  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1;
  logic if_req = 1'b0, if_clear = 1'b0, mem_req = 1'b0, mem_we = 1'b0, io_full = 1'b0;
  logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
  logic [2:0]  mem_len = '0;
  logic [31:0] if_data, mem_rdata;
  logic        if_done, mem_done, mem_busy, ram_wr;
  logic [7:0]  ram_din, ram_dout;
  logic [RAM_ADDR_W-1:0] ram_a;

  logic [7:0]  ram_mem [RAM_SIZE];
  logic [7:0]  ref_mem [RAM_SIZE];
  logic [25:0] wlog [$];
  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered-read RAM; it shares the global ready with the rest of the system.
  always @(posedge clk) begin
    if (rdy) begin
      ram_din <= ram_mem[ram_a];
      if (ram_wr) begin
        ram_mem[ram_a] = ram_dout;
        wlog.push_back({ram_a, ram_dout});
      end
    end
  end

  mem_arbiter_ctrl #(
    .ADDR_W     (32),
    .RAM_ADDR_W (RAM_ADDR_W),
    .IO_REGION  (2'b11)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_clear  (if_clear),
    .if_data   (if_data),
    .if_done   (if_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_len   (mem_len),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done),
    .mem_busy  (mem_busy),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .ram_a     (ram_a),
    .ram_wr    (ram_wr),
    .io_full   (io_full)
  );

  function automatic int nb(input logic [2:0] len);
    return (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] len);
    logic [31:0] v = '0;
    for (int i = 0; i < nb(len); i++) v[8*i +: 8] = ref_mem[18'(a + 32'(i))];
    return v;
  endfunction

  task automatic if_txn(input logic [31:0] a, output logic [31:0] d, output int lat,
                        output int busy_hi);
    int t0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = a; t0 = cyc; lat = -1; d = 'x; busy_hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_busy) busy_hi++;
      if (if_done) begin lat = cyc - t0; d = if_data; break; end
    end
    if_req = 1'b0;
  endtask

  task automatic mem_txn(input logic we, input logic [2:0] len, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output int lat,
                         output int busy_lo);
    int t0;
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = a; mem_wdata = wd;
    t0 = cyc; lat = -1; rd = 'x; busy_lo = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_done) begin lat = cyc - t0; rd = mem_rdata; break; end
      if (!mem_busy) busy_lo++;
    end
    mem_req = 1'b0;
  endtask

  task automatic test_reset();
    mem_req = 1'b1;
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({if_data, mem_rdata, ram_dout, ram_a, ram_wr, if_done, mem_done, mem_busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {if_data, mem_rdata, ram_dout, ram_a, ram_wr, if_done, mem_done, mem_busy});
    end
    mem_req = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({ram_wr, if_done, mem_done, mem_busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %b expected 0000", {ram_wr, if_done, mem_done, mem_busy});
    end
  endtask

  task automatic test_if_read();
    logic [31:0] d; int lat, b;
    logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      ram_mem[32'h100 + i] = bytes[i]; ref_mem[32'h100 + i] = bytes[i];
    end
    if_txn(32'h0000_0100, d, lat, b);
    n_cmp++;
    if (d !== 32'h4433_2211) begin n_fail++; $display("FAIL if_read_data: got %h expected 44332211", d); end
    n_cmp++;
    if (lat != 6) begin n_fail++; $display("FAIL if_read_latency: got %0d expected 6", lat); end
    n_cmp++;
    if (b != 0) begin n_fail++; $display("FAIL if_read_busy: got %0d busy cycles expected 0", b); end
  endtask

  task automatic test_simultaneous();
    int t0, md = -1, id = -1;
    logic [31:0] mrd = 'x, ird = 'x;
    ram_mem[32'h200] = 8'hA5; ref_mem[32'h200] = 8'hA5;
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 3'd1; mem_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'h480; t0 = cyc;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_done && md < 0) begin md = cyc - t0; mrd = mem_rdata; mem_req = 1'b0; end
      if (if_done && id < 0) begin id = cyc - t0; ird = if_data; if_req = 1'b0; end
      if (md >= 0 && id >= 0) break;
    end
    mem_req = 1'b0; if_req = 1'b0;
    n_cmp++;
    if (mrd !== 32'h0000_00A5) begin n_fail++; $display("FAIL simul_mem_data: got %h expected 000000a5", mrd); end
    n_cmp++;
    if (md != 3) begin n_fail++; $display("FAIL simul_mem_latency: got %0d expected 3", md); end
    n_cmp++;
    if (id != 10) begin n_fail++; $display("FAIL simul_if_latency: got %0d expected 10", id); end
    n_cmp++;
    if (ird !== ref_load(32'h480, 3'd4)) begin
      n_fail++; $display("FAIL simul_if_data: got %h expected %h", ird, ref_load(32'h480, 3'd4));
    end
  endtask

  task automatic test_store_wrap();
    logic [31:0] rd; int lat, b; logic [25:0] w0, w1; int sz;
    wlog.delete();
    mem_txn(1'b1, 3'd2, 32'h0003_FFFF, 32'h1234_BEEF, rd, lat, b);
    sz = wlog.size();
    w0 = (sz > 0) ? wlog[0] : '1;
    w1 = (sz > 1) ? wlog[1] : '1;
    ref_mem[18'h3FFFF] = 8'hEF; ref_mem[18'h00000] = 8'hBE;
    n_cmp++;
    if (lat != 3) begin n_fail++; $display("FAIL wrap_latency: got %0d expected 3", lat); end
    n_cmp++;
    if (sz != 2) begin n_fail++; $display("FAIL wrap_write_count: got %0d expected 2", sz); end
    n_cmp++;
    if (w0 !== {18'h3FFFF, 8'hEF}) begin n_fail++; $display("FAIL wrap_write0: got %h expected %h", w0, {18'h3FFFF, 8'hEF}); end
    n_cmp++;
    if (w1 !== {18'h00000, 8'hBE}) begin n_fail++; $display("FAIL wrap_write1: got %h expected %h", w1, {18'h00000, 8'hBE}); end
    n_cmp++;
    if (b != 0) begin n_fail++; $display("FAIL wrap_busy: got %0d idle-busy cycles expected 0", b); end
  endtask

  task automatic test_if_clear();
    int t0, ifd = 0, md = -1;
    logic [31:0] mrd = 'x;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h500; t0 = cyc;
    for (int c = 0; c < 16; c++) begin
      if (c == 3) if_clear = 1'b1;
      if (c == 4) begin
        if_req = 1'b0; mem_req = 1'b1; mem_we = 1'b0; mem_len = 3'd4; mem_addr = 32'h600;
      end
      @(negedge clk);
      if (if_done) ifd++;
      if (mem_done && md < 0) begin md = cyc - t0; mrd = mem_rdata; mem_req = 1'b0; end
      @(posedge clk); #1;
    end
    if_clear = 1'b0; mem_req = 1'b0;
    n_cmp++;
    if (ifd != 0) begin n_fail++; $display("FAIL clear_no_if_done: got %0d pulses expected 0", ifd); end
    n_cmp++;
    if (md != 10) begin n_fail++; $display("FAIL clear_mem_latency: got %0d expected 10", md); end
    n_cmp++;
    if (mrd !== ref_load(32'h600, 3'd4)) begin
      n_fail++; $display("FAIL clear_mem_data: got %h expected %h", mrd, ref_load(32'h600, 3'd4));
    end
  endtask

  task automatic test_stall_reset();
    int t0, md = -1, hold_err = 0, seen = 0, lat, b;
    logic [31:0] mrd = 'x, d;
    logic [RAM_ADDR_W-1:0] a_hold = '0;
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 3'd4; mem_addr = 32'h700; t0 = cyc;
    for (int c = 0; c < 20; c++) begin
      if (c == 2) begin rdy = 1'b0; a_hold = ram_a; end
      if (c == 5) rdy = 1'b1;
      @(negedge clk);
      if (c >= 2 && c < 5 && ram_a !== a_hold) hold_err++;
      if (mem_done && md < 0) begin md = cyc - t0; mrd = mem_rdata; mem_req = 1'b0; end
      @(posedge clk); #1;
    end
    mem_req = 1'b0;
    n_cmp++;
    if (md != 9) begin n_fail++; $display("FAIL stall_latency: got %0d expected 9", md); end
    n_cmp++;
    if (mrd !== ref_load(32'h700, 3'd4)) begin
      n_fail++; $display("FAIL stall_data: got %h expected %h", mrd, ref_load(32'h700, 3'd4));
    end
    n_cmp++;
    if (hold_err != 0) begin n_fail++; $display("FAIL stall_addr_hold: got %0d changes expected 0", hold_err); end

    wlog.delete();
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 3'd4; mem_addr = 32'h800; mem_wdata = $urandom;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({if_data, mem_rdata, ram_dout, ram_a, ram_wr, if_done, mem_done, mem_busy} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got %h expected 0",
               {if_data, mem_rdata, ram_dout, ram_a, ram_wr, if_done, mem_done, mem_busy});
    end
    for (int c = 0; c < 3; c++) begin @(negedge clk); if (mem_done) seen++; end
    mem_req = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    for (int c = 0; c < 6; c++) begin @(negedge clk); if (mem_done || if_done) seen++; end
    n_cmp++;
    if (seen != 0) begin n_fail++; $display("FAIL reset_no_done: got %0d pulses expected 0", seen); end
    n_cmp++;
    if (wlog.size() != 1) begin n_fail++; $display("FAIL reset_abort_writes: got %0d writes expected 1", wlog.size()); end
    if_txn(32'h100, d, lat, b);
    n_cmp++;
    if (lat != 6 || d !== 32'h4433_2211) begin
      n_fail++; $display("FAIL post_reset_fetch: got lat %0d data %h expected lat 6 data 44332211", lat, d);
    end
  endtask

  task automatic test_io_write();
    int t0, md = -1, early = 0;
    wlog.delete();
    io_full = 1'b1;
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 3'd1; mem_addr = 32'h0003_0000; mem_wdata = 32'h0000_005A;
    t0 = cyc;
    for (int c = 0; c < 16; c++) begin
      if (c == 5) io_full = 1'b0;
      @(negedge clk);
      if (c >= 1 && c < 5 && ram_wr) early++;
      if (mem_done && md < 0) begin md = cyc - t0; mem_req = 1'b0; end
      @(posedge clk); #1;
    end
    mem_req = 1'b0; io_full = 1'b0;
    ref_mem[18'h30000] = 8'h5A;
    n_cmp++;
    if (early != IO_EARLY_WR) begin n_fail++; $display("FAIL io_early_write: got %0d expected %0d", early, IO_EARLY_WR); end
    n_cmp++;
    if (md != IO_DONE_LAT) begin n_fail++; $display("FAIL io_latency: got %0d expected %0d", md, IO_DONE_LAT); end
    n_cmp++;
    if (wlog.size() != 1 || wlog[0] !== {18'h30000, 8'h5A}) begin
      n_fail++; $display("FAIL io_write: got %0d writes expected one of %h", wlog.size(), {18'h30000, 8'h5A});
    end
  endtask

  task automatic test_random();
    logic [31:0] a, wd, d, exp;
    logic [2:0]  len;
    logic [25:0] e, g;
    int k, n, lat, b;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) a = 32'h3FFF8 + $urandom_range(0, 7);
      else a = 32'h1000 + $urandom_range(0, 255);
      a[31:18] = 14'($urandom);
      len = 3'($urandom_range(0, 7));
      wd = $urandom;
      n = nb(len);
      if (k == 0) begin
        exp = ref_load(a, 3'd4);
        if_txn(a, d, lat, b);
        n_cmp++;
        if (d !== exp) begin n_fail++; $display("FAIL rand_if_data[%0d]: got %h expected %h", i, d, exp); end
        n_cmp++;
        if (lat != 6 || b != 0) begin
          n_fail++; $display("FAIL rand_if_timing[%0d]: got lat %0d busy %0d expected lat 6 busy 0", i, lat, b);
        end
      end else if (k == 1) begin
        if_clear = 1'($urandom);
        exp = ref_load(a, len);
        mem_txn(1'b0, len, a, 32'h0, d, lat, b);
        if_clear = 1'b0;
        n_cmp++;
        if (d !== exp) begin n_fail++; $display("FAIL rand_load_data[%0d]: got %h expected %h", i, d, exp); end
        n_cmp++;
        if (lat != n + 2 || b != 0) begin
          n_fail++; $display("FAIL rand_load_timing[%0d]: got lat %0d busy-low %0d expected lat %0d busy-low 0", i, lat, b, n + 2);
        end
      end else begin
        if_clear = 1'($urandom);
        wlog.delete();
        mem_txn(1'b1, len, a, wd, d, lat, b);
        if_clear = 1'b0;
        n_cmp++;
        if (lat != n + 1 || b != 0 || wlog.size() != n) begin
          n_fail++;
          $display("FAIL rand_store_timing[%0d]: got lat %0d busy-low %0d writes %0d expected lat %0d busy-low 0 writes %0d",
                   i, lat, b, wlog.size(), n + 1, n);
        end
        for (int j = 0; j < n; j++) begin
          e = {18'(a + 32'(j)), wd[8*j +: 8]};
          g = (j < wlog.size()) ? wlog[j] : '1;
          ref_mem[18'(a + 32'(j))] = wd[8*j +: 8];
          n_cmp++;
          if (g !== e) begin n_fail++; $display("FAIL rand_store_byte[%0d.%0d]: got %h expected %h", i, j, g, e); end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < RAM_SIZE; i++) begin
      ram_mem[i] = 8'($urandom);
      ref_mem[i] = ram_mem[i];
    end
    test_reset();
    test_if_read();
    test_simultaneous();
    test_store_wrap();
    test_if_clear();
    test_stall_reset();
    test_io_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
